coin_event_arbiter: RTL and testbench
=====================================

Name: coin_event_arbiter

Overview:
- Front-end scheduler between the four raw coin sensors and the vending credit state machine.
- Glitch-filters each sensor and converts each sustained high level into exactly one coin event.
- Arbitrates simultaneous events round-robin and buffers them in a small FIFO.
- Presents one coin at a time to the credit FSM over a valid/ready handshake, so no coin is lost or double-counted.

Parameters:
- FIFO_DEPTH, 4: coin event FIFO entries; power of 2, range 2..8.
- MIN_HIGH, 2: consecutive sampled-high cycles needed to accept a coin; range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted, release synchronous to clk.
- coin_01rs  input  1  Rs1 sensor level, already synchronised to clk.
- coin_02rs  input  1  Rs2 sensor level.
- coin_05rs  input  1  Rs5 sensor level.
- coin_10rs  input  1  Rs10 sensor level.
- coin_valid  output  1  FIFO head holds a coin event.
- coin_id  output  2  head coin index: 0=Rs1, 1=Rs2, 2=Rs5, 3=Rs10.
- coin_value  output  4  head coin value in rupees: 1, 2, 5 or 10.
- coin_ready  input  1  credit FSM accepts the head this cycle.
- fifo_count  output  4  number of occupied FIFO entries, 0..FIFO_DEPTH.
- overflow  output  1  sticky flag: a coin event was lost.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, asynchronous), all state cleared:
  - coin_valid=0, coin_id=0, coin_value=0, fifo_count=0, overflow=0.
  - Filter counters, armed bits and pending bits = 0.
  - Round-robin pointer = index 0.
  - A reset mid-operation discards queued and pending coins.
- Filter, per sensor i:
  - 4-bit counter cnt[i] increments each cycle the input is 1, saturating at MIN_HIGH, and clears when the input is 0.
  - On the edge where cnt[i] reaches MIN_HIGH, one detect pulse is generated and armed[i] is set.
  - armed[i] clears only when the input returns to 0, so one held-high coin yields exactly one event.
  - A high run shorter than MIN_HIGH yields nothing.
- Pending: pend[i] is set by detect[i] and cleared on grant[i].
  - If detect[i] occurs while pend[i] is already 1 and not granted in the same cycle, the event is dropped and overflow is set.
- Arbiter:
  - Each cycle, if any pend bit is set and push is allowed, grant exactly one index.
  - The grant goes to the first pending index at or after the round-robin pointer, wrapping 3 to 0.
  - After a grant, pointer = granted index + 1, modulo 4.
  - Without a grant, the pointer holds.
- Push allowed when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop/push keeps count at FIFO_DEPTH).
- While the FIFO is full and there is no pop, pend bits hold; no coin is lost unless the same coin type re-detects (overflow rule above).
- FIFO: pop when coin_valid && coin_ready.
  - coin_valid = (fifo_count != 0).
  - coin_id and coin_value are driven registered from the head entry; coin_value is a lookup of coin_id.
  - coin_id and coin_value are 0 when the FIFO is empty.
  - Head values are stable while coin_valid=1 and coin_ready=0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_count: +1 on push only, -1 on pop only, unchanged on both.
- Latency, sensor high first sampled on edge E:
  - detect and pend set on edge E+MIN_HIGH-1.
  - grant/push on edge E+MIN_HIGH.
  - coin_valid=1 after edge E+MIN_HIGH, assuming no contention and FIFO not full.
- overflow: set has priority over overflow_clr in the same cycle.

Test Plan:
- Rs5 high 4 cycles, coin_ready=1 → one event, coin_valid high one cycle with coin_id=2, coin_value=5; fifo_count returns to 0.
- Rs1 pulses high 1 cycle (MIN_HIGH=2) → no event; coin_valid stays 0.
- All four sensors rise together after reset, coin_ready=0 → FIFO order 1, 2, 5, 10; fifo_count=4; head is coin_value=1 until coin_ready pulses.
- FIFO full, coin_ready=0, then Rs2 inserted → pend held, fifo_count=4, no overflow; coin_ready for 1 cycle → push and pop together, count stays 4, Rs2 enters the tail.
- FIFO full with Rs10 pending, then a second Rs10 inserted (low, then high ≥ MIN_HIGH) → overflow=1; only one Rs10 delivered; overflow_clr → 0.
- Three coins queued, rst pulsed low mid-cycle → outputs 0 immediately (asynchronous); after release no stale coins appear; next Rs1 insert is delivered first.

Source files
------------

// File: rtl/coin_event_arbiter.sv
// Coin sensor front-end: per-sensor glitch filter, round-robin arbiter and event FIFO
// feeding the credit FSM one coin at a time over a valid/ready handshake.
module coin_event_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_HIGH   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_01rs,
  input  logic       coin_02rs,
  input  logic       coin_05rs,
  input  logic       coin_10rs,
  output logic       coin_valid,
  output logic [1:0] coin_id,
  output logic [3:0] coin_value,
  input  logic       coin_ready,
  output logic [3:0] fifo_count,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MIN_CNT = 4'(MIN_HIGH);
  localparam logic [3:0] MIN_M1  = 4'(MIN_HIGH - 1);
  localparam logic [3:0] DEPTH   = 4'(FIFO_DEPTH);

  function automatic logic [3:0] coin_lut(input logic [1:0] id);
    case (id)
      2'd0:    coin_lut = 4'd1;
      2'd1:    coin_lut = 4'd2;
      2'd2:    coin_lut = 4'd5;
      default: coin_lut = 4'd10;
    endcase
  endfunction

  logic [3:0] sensor;
  logic [3:0] cnt_reg [4];
  logic [3:0] armed_reg;
  logic [3:0] detect;
  logic [3:0] pend_reg;
  logic [1:0] rr_ptr_reg;

  assign sensor = {coin_10rs, coin_05rs, coin_02rs, coin_01rs};

  // armed blocks a second detect until the sensor drops, so a held coin counts once.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_filter
      assign detect[gi] = sensor[gi] && (cnt_reg[gi] == MIN_M1) && !armed_reg[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi]   <= '0;
          armed_reg[gi] <= 1'b0;
        end else if (!sensor[gi]) begin
          cnt_reg[gi]   <= '0;
          armed_reg[gi] <= 1'b0;
        end else begin
          if (cnt_reg[gi] != MIN_CNT) cnt_reg[gi] <= cnt_reg[gi] + 4'd1;
          if (detect[gi]) armed_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  logic          pop;
  logic          push_ok;
  logic          push;
  logic [3:0]    grant;
  logic [1:0]    grant_id;
  logic          found;
  logic [1:0]    idx;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [3:0]    count_next;
  logic [1:0]    head_id_next;
  logic [1:0]    mem [FIFO_DEPTH];

  assign coin_valid = (fifo_count != 4'd0);
  assign pop        = coin_valid && coin_ready;
  assign push_ok    = (fifo_count < DEPTH) || pop;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_reg + 2'(k);
      if (push_ok && !found && pend_reg[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  assign push = found;

  always_comb begin
    count_next   = fifo_count;
    if (push && !pop) count_next = fifo_count + 4'd1;
    if (pop && !push) count_next = fifo_count - 4'd1;
    rd_ptr_next  = rd_ptr_reg + AW'(pop);
    // A push landing on the new head slot is not in the array yet, so bypass it.
    if (count_next == 4'd0)                      head_id_next = 2'd0;
    else if (push && rd_ptr_next == wr_ptr_reg)  head_id_next = grant_id;
    else                                         head_id_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= grant_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_reg   <= '0;
      rr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      fifo_count <= '0;
      coin_id    <= '0;
      coin_value <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_reg   <= (pend_reg & ~grant) | detect;
      if (push) begin
        rr_ptr_reg <= grant_id + 2'd1;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      fifo_count <= count_next;
      coin_id    <= head_id_next;
      coin_value <= (count_next == 4'd0) ? 4'd0 : coin_lut(head_id_next);
      if (|(detect & pend_reg & ~grant)) overflow <= 1'b1;
      else if (overflow_clr)             overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coin_event_arbiter.sv
// Directed bench for coin_event_arbiter (FIFO_DEPTH=4, MIN_HIGH=2).
module tb_coin_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_01rs, coin_02rs, coin_05rs, coin_10rs;
  logic       coin_valid;
  logic [1:0] coin_id;
  logic [3:0] coin_value;
  logic       coin_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;

  int check_count = 0;
  int fail_count  = 0;

  coin_event_arbiter #(.FIFO_DEPTH(4), .MIN_HIGH(2)) dut (
    .clk(clk), .rst(rst),
    .coin_01rs(coin_01rs), .coin_02rs(coin_02rs),
    .coin_05rs(coin_05rs), .coin_10rs(coin_10rs),
    .coin_valid(coin_valid), .coin_id(coin_id), .coin_value(coin_value),
    .coin_ready(coin_ready), .fifo_count(fifo_count),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic check_head(input string tag, input int v, input int id, input int val, input int cnt);
    check_eq({tag, ".valid"}, 32'(coin_valid), 32'(v));
    check_eq({tag, ".id"},    32'(coin_id),    32'(id));
    check_eq({tag, ".value"}, 32'(coin_value), 32'(val));
    check_eq({tag, ".count"}, 32'(fifo_count), 32'(cnt));
  endtask

  int exp_id  [4] = '{2, 3, 1, 3};
  int exp_val [4] = '{5, 10, 2, 10};
  int exp_cnt [4] = '{4, 3, 2, 1};

  initial begin
    rst = 1'b0;
    {coin_01rs, coin_02rs, coin_05rs, coin_10rs} = 4'b0;
    coin_ready = 1'b0;
    overflow_clr = 1'b0;
    tick(2);
    check_head("reset", 0, 0, 0, 0);
    check_eq("reset.overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick(1);

    // Rs5 held 4 cycles with ready high: one event, one valid cycle.
    coin_ready = 1'b1;
    coin_05rs  = 1'b1;
    tick(2);
    check_head("rs5.before", 0, 0, 0, 0);
    tick(1);
    check_head("rs5.valid", 1, 2, 5, 1);
    tick(1);
    check_head("rs5.popped", 0, 0, 0, 0);
    coin_05rs = 1'b0;
    tick(3);
    check_head("rs5.after", 0, 0, 0, 0);

    // One-cycle glitch on Rs1 is filtered out.
    coin_01rs = 1'b1;
    tick(1);
    coin_01rs = 1'b0;
    tick(4);
    check_head("glitch", 0, 0, 0, 0);

    // Reset, then all four together with ready low: order 1,2,5,10.
    coin_ready = 1'b0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    {coin_01rs, coin_02rs, coin_05rs, coin_10rs} = 4'b1111;
    tick(2);
    check_head("all.pend", 0, 0, 0, 0);
    tick(1);
    check_head("all.first", 1, 0, 1, 1);
    tick(3);
    check_head("all.full", 1, 0, 1, 4);
    {coin_01rs, coin_02rs, coin_05rs, coin_10rs} = 4'b0000;
    tick(2);
    check_head("all.stable", 1, 0, 1, 4);

    // Full FIFO: Rs2 waits in pend, then pop+push keeps count at 4.
    coin_02rs = 1'b1;
    tick(4);
    check_head("full.rs2wait", 1, 0, 1, 4);
    check_eq("full.overflow", 32'(overflow), 32'd0);
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    check_head("full.swap", 1, 1, 2, 4);
    coin_02rs = 1'b0;
    tick(1);

    // Second Rs10 while the first is still pending: lost, overflow set.
    coin_10rs = 1'b1;
    tick(2);
    check_eq("ovf.first", 32'(overflow), 32'd0);
    coin_10rs = 1'b0;
    tick(1);
    coin_10rs = 1'b1;
    tick(2);
    check_eq("ovf.set", 32'(overflow), 32'd1);
    check_eq("ovf.count", 32'(fifo_count), 32'd4);
    coin_10rs = 1'b0;
    tick(1);
    coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_head($sformatf("drain%0d", i), 1, exp_id[i], exp_val[i], exp_cnt[i]);
    end
    tick(1);
    check_head("drain.empty", 0, 0, 0, 0);
    tick(3);
    check_head("drain.noextra", 0, 0, 0, 0);
    check_eq("ovf.sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check_eq("ovf.clr", 32'(overflow), 32'd0);

    // Three coins queued, asynchronous reset mid-cycle discards them.
    coin_ready = 1'b0;
    {coin_01rs, coin_02rs, coin_05rs, coin_10rs} = 4'b0111;
    tick(5);
    check_eq("q3.count", 32'(fifo_count), 32'd3);
    {coin_01rs, coin_02rs, coin_05rs, coin_10rs} = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    check_head("async.rst", 0, 0, 0, 0);
    tick(1);
    rst = 1'b1;
    tick(2);
    check_head("post.rst", 0, 0, 0, 0);
    coin_01rs = 1'b1;
    tick(3);
    check_head("post.rs1", 1, 0, 1, 1);
    coin_01rs = 1'b0;
    coin_ready = 1'b1;
    tick(1);
    check_head("post.pop", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
